// File: rtl/nfifo2_pkg.sv
// Shared types and width helpers for the multi-flow FIFO.
package nfifo2_pkg;

  typedef enum logic {
    MODE_ADDR, // reader names the flow on RD_BLK_ADDR
    MODE_RR    // internal round-robin picks the next non-empty flow
  } read_mode_t;

  // Width of a flow index (at least one bit).
  function automatic int flow_width(input int flows);
    return (flows > 1) ? $clog2(flows) : 1;
  endfunction

  // Width of an occupancy count: must hold 0..BLOCK_SIZE inclusive.
  function automatic int count_width(input int block_size);
    return $clog2(block_size) + 1;
  endfunction

endpackage

// File: rtl/nfifo2_rr_arb.sv
// Round-robin flow selector: grants the first requesting flow at or above
// (last served + 1), wrapping; the last-served pointer moves only on accept.
module nfifo2_rr_arb
  import nfifo2_pkg::*;
#(
  parameter int FLOWS = 4,
  localparam int FW = flow_width(FLOWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FLOWS-1:0] req,
  input  logic             accept,
  output logic [FW-1:0]    grant
);

  logic [FW-1:0] last_q;
  logic [FW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  // NOTE: every variable written in always_comb is given a value first so no latch is inferred.
  always_comb begin
    grant = last_q;
    cand  = '0;
    for (int i = FLOWS; i >= 1; i--) begin
      cand = FW'((int'(last_q) + i) % FLOWS);
      if (req[cand]) grant = cand;
    end
  end

  // Last-served register; starts at FLOWS-1 so the first search begins at flow 0.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= FW'(FLOWS - 1);
    else if (accept) last_q <= grant;
  end

endmodule

// File: rtl/nfifo2.sv
// Multi-flow FIFO: FLOWS circular buffers of BLOCK_SIZE words in one shared
// array, one write port, one registered read port, per-flow status flags.
module nfifo2
  import nfifo2_pkg::*;
#(
  parameter int         DATA_WIDTH   = 64,
  parameter int         FLOWS        = 4,
  parameter int         BLOCK_SIZE   = 16,
  parameter int         AFULL_THRESH = 12,
  parameter read_mode_t READ_MODE    = MODE_ADDR,
  localparam int        FW           = flow_width(FLOWS),
  localparam int        CW           = count_width(BLOCK_SIZE)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic [FW-1:0]         WR_BLK_ADDR,
  input  logic                  WRITE,
  output logic [FLOWS-1:0]      FULL,
  output logic [FLOWS-1:0]      AFULL,
  output logic                  DROP,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic [FW-1:0]         DATA_FLOW,
  output logic                  DATA_VLD,
  input  logic [FW-1:0]         RD_BLK_ADDR,
  input  logic                  READ,
  output logic [FLOWS-1:0]      EMPTY,
  output logic [FLOWS*CW-1:0]   STATUS
);

  localparam int PW    = $clog2(BLOCK_SIZE);
  localparam int DEPTH = FLOWS * BLOCK_SIZE;

  // Flow f owns addresses f*BLOCK_SIZE + ptr, i.e. {f, ptr} since BLOCK_SIZE is 2^PW.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q   [FLOWS];
  logic [PW-1:0]    rd_ptr_q   [FLOWS];
  logic [CW-1:0]    count_q    [FLOWS];
  logic [CW-1:0]    count_next [FLOWS];
  logic [FLOWS-1:0] full_q;
  logic [FLOWS-1:0] afull_q;
  logic [FLOWS-1:0] empty_q;

  logic [FW-1:0] grant;
  logic [FW-1:0] rd_flow;
  logic          wr_accept;
  logic          rd_accept;

  // Acceptance uses the registered flags, so a full flow drops writes even
  // with a same-cycle read, and an empty flow is never bypassed by a write.
  assign wr_accept = WRITE && !full_q[WR_BLK_ADDR];
  assign rd_flow   = (READ_MODE == MODE_RR) ? grant : RD_BLK_ADDR;
  assign rd_accept = READ && !empty_q[rd_flow];

  nfifo2_rr_arb #(
    .FLOWS (FLOWS)
  ) u_arb (
    .clk    (CLK),
    .rst    (RESET),
    .req    (~empty_q),
    .accept (rd_accept && (READ_MODE == MODE_RR)),
    .grant  (grant)
  );

  // Next occupancy per flow: +1 on accepted write, -1 on accepted read.
  always_comb begin
    for (int f = 0; f < FLOWS; f++) begin
      count_next[f] = count_q[f]
                    + CW'(wr_accept && (WR_BLK_ADDR == FW'(f)))
                    - CW'(rd_accept && (rd_flow == FW'(f)));
    end
  end

  // Pointers, counts and registered flags derived from the next count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int f = 0; f < FLOWS; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        count_q[f]  <= '0;
      end
      full_q  <= '0;
      afull_q <= '0;
      empty_q <= '1;
    end else begin
      if (wr_accept) wr_ptr_q[WR_BLK_ADDR] <= wr_ptr_q[WR_BLK_ADDR] + PW'(1);
      if (rd_accept) rd_ptr_q[rd_flow]     <= rd_ptr_q[rd_flow] + PW'(1);
      for (int f = 0; f < FLOWS; f++) begin
        count_q[f] <= count_next[f];
        full_q[f]  <= (count_next[f] == CW'(BLOCK_SIZE));
        afull_q[f] <= (count_next[f] >= CW'(AFULL_THRESH));
        empty_q[f] <= (count_next[f] == '0);
      end
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; resetting the pointers empties it logically, and a reset would block RAM inference.
  always_ff @(posedge CLK) begin
    if (wr_accept) mem[{WR_BLK_ADDR, wr_ptr_q[WR_BLK_ADDR]}] <= DATA_IN;
  end

  // Registered read port plus the one-cycle valid and drop pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DATA_OUT  <= '0;
      DATA_FLOW <= '0;
      DATA_VLD  <= 1'b0;
      DROP      <= 1'b0;
    end else begin
      DATA_VLD <= rd_accept;
      DROP     <= WRITE && !wr_accept;
      if (rd_accept) begin
        DATA_OUT  <= mem[{rd_flow, rd_ptr_q[rd_flow]}];
        DATA_FLOW <= rd_flow;
      end
    end
  end

  // Pack per-flow occupancy into the STATUS bus.
  always_comb begin
    STATUS = '0;
    for (int f = 0; f < FLOWS; f++) STATUS[f*CW +: CW] = count_q[f];
  end

  assign FULL  = full_q;
  assign AFULL = afull_q;
  assign EMPTY = empty_q;

endmodule

// File: tb/tb_nfifo2.sv
// Directed bench for nfifo2: one address-mode and one round-robin instance
// share stimulus; each scenario checks the instance it targets.
module tb_nfifo2;
  import nfifo2_pkg::*;

  localparam int DW = 16;
  localparam int NF = 4;
  localparam int BS = 8;
  localparam int AT = 6;
  localparam int FW = 2;
  localparam int CW = 4;

  typedef struct {
    logic          wr;
    logic [FW-1:0] wa;
    logic [DW-1:0] din;
    logic          rd;
    logic [FW-1:0] ra;
    logic [NF-1:0] full;
    logic [NF-1:0] afull;
    logic [NF-1:0] empty;
    logic          drop;
    logic          vld;
    logic [DW-1:0] dout;
    logic [FW-1:0] dflow;
    logic [15:0]   status;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] din;
  logic [FW-1:0] wa, ra;
  logic wr, rd;

  logic [NF-1:0]    full_a, afull_a, empty_a, full_r, afull_r, empty_r;
  logic             drop_a, vld_a, drop_r, vld_r;
  logic [DW-1:0]    dout_a, dout_r;
  logic [FW-1:0]    dflow_a, dflow_r;
  logic [NF*CW-1:0] status_a, status_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nfifo2 #(.DATA_WIDTH(DW), .FLOWS(NF), .BLOCK_SIZE(BS), .AFULL_THRESH(AT),
           .READ_MODE(MODE_ADDR)) dut_a (
    .CLK(clk), .RESET(rst), .DATA_IN(din), .WR_BLK_ADDR(wa), .WRITE(wr),
    .FULL(full_a), .AFULL(afull_a), .DROP(drop_a), .DATA_OUT(dout_a),
    .DATA_FLOW(dflow_a), .DATA_VLD(vld_a), .RD_BLK_ADDR(ra), .READ(rd),
    .EMPTY(empty_a), .STATUS(status_a)
  );

  nfifo2 #(.DATA_WIDTH(DW), .FLOWS(NF), .BLOCK_SIZE(BS), .AFULL_THRESH(AT),
           .READ_MODE(MODE_RR)) dut_r (
    .CLK(clk), .RESET(rst), .DATA_IN(din), .WR_BLK_ADDR(wa), .WRITE(wr),
    .FULL(full_r), .AFULL(afull_r), .DROP(drop_r), .DATA_OUT(dout_r),
    .DATA_FLOW(dflow_r), .DATA_VLD(vld_r), .RD_BLK_ADDR(ra), .READ(rd),
    .EMPTY(empty_r), .STATUS(status_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [FW-1:0] a, input logic [DW-1:0] d,
                       input logic r, input logic [FW-1:0] b);
    wr = w; wa = a; din = d; rd = r; ra = b;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected STATUS word with a single flow holding cnt words.
  function automatic logic [15:0] st(input int flow, input int cnt);
    logic [15:0] v;
    v = '0;
    v[flow*CW +: CW] = CW'(cnt);
    return v;
  endfunction

  vec_t tbl [17];
  int   seq [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill/overflow/drain vectors for flow 2, expected values from occupancy c.
    for (int k = 0; k < 9; k++) begin
      int c;
      c = (k + 1 > BS) ? BS : k + 1;
      tbl[k].wr = 1'b1; tbl[k].wa = 2'd2; tbl[k].din = 16'(k + 1);
      tbl[k].rd = 1'b0; tbl[k].ra = 2'd0;
      tbl[k].full   = (c == BS) ? 4'b0100 : 4'b0000;
      tbl[k].afull  = (c >= AT) ? 4'b0100 : 4'b0000;
      tbl[k].empty  = 4'b1011;
      tbl[k].drop   = (k == 8);
      tbl[k].vld    = 1'b0;
      tbl[k].dout   = '0;
      tbl[k].dflow  = '0;
      tbl[k].status = st(2, c);
    end
    for (int j = 0; j < 8; j++) begin
      int c;
      c = 7 - j;
      tbl[9+j].wr = 1'b0; tbl[9+j].wa = 2'd0; tbl[9+j].din = '0;
      tbl[9+j].rd = 1'b1; tbl[9+j].ra = 2'd2;
      tbl[9+j].full   = 4'b0000;
      tbl[9+j].afull  = (c >= AT) ? 4'b0100 : 4'b0000;
      tbl[9+j].empty  = (c == 0) ? 4'b1111 : 4'b1011;
      tbl[9+j].drop   = 1'b0;
      tbl[9+j].vld    = 1'b1;
      tbl[9+j].dout   = 16'(j + 1);
      tbl[9+j].dflow  = 2'd2;
      tbl[9+j].status = st(2, c);
    end

    do_reset();

    // Reset state.
    check("reset.empty",  32'(empty_a),  32'hF);
    check("reset.full",   32'(full_a),   0);
    check("reset.afull",  32'(afull_a),  0);
    check("reset.status", 32'(status_a), 0);
    check("reset.vld",    32'(vld_a),    0);
    check("reset.drop",   32'(drop_a),   0);
    check("reset.dout",   32'(dout_a),   0);
    check("reset.dflow",  32'(dflow_a),  0);

    // Fill and overflow, then drain (table driven).
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].wr, tbl[i].wa, tbl[i].din, tbl[i].rd, tbl[i].ra);
      tick();
      check($sformatf("fill[%0d].full", i),   32'(full_a),   32'(tbl[i].full));
      check($sformatf("fill[%0d].afull", i),  32'(afull_a),  32'(tbl[i].afull));
      check($sformatf("fill[%0d].empty", i),  32'(empty_a),  32'(tbl[i].empty));
      check($sformatf("fill[%0d].drop", i),   32'(drop_a),   32'(tbl[i].drop));
      check($sformatf("fill[%0d].vld", i),    32'(vld_a),    32'(tbl[i].vld));
      check($sformatf("fill[%0d].status", i), 32'(status_a), 32'(tbl[i].status));
      if (tbl[i].vld) begin
        check($sformatf("fill[%0d].dout", i),  32'(dout_a),  32'(tbl[i].dout));
        check($sformatf("fill[%0d].dflow", i), 32'(dflow_a), 32'(tbl[i].dflow));
      end
    end

    // Empty read of flow 1: nothing comes out.
    drive(1'b0, '0, '0, 1'b1, 2'd1);
    tick();
    check("empty_rd.vld",   32'(vld_a),   0);
    check("empty_rd.empty", 32'(empty_a), 32'hF);

    // Three fill/drain rounds on flow 1 exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 2'd1, 16'(16'h0100 + r*8 + i), 1'b0, '0);
        tick();
      end
      check($sformatf("wrap[%0d].status_full", r), 32'(status_a), 32'(st(1, 8)));
      check($sformatf("wrap[%0d].full", r),        32'(full_a),   32'h2);
      for (int i = 0; i < 8; i++) begin
        drive(1'b0, '0, '0, 1'b1, 2'd1);
        tick();
        check($sformatf("wrap[%0d][%0d].vld", r, i),  32'(vld_a),  1);
        check($sformatf("wrap[%0d][%0d].dout", r, i), 32'(dout_a), 32'(16'h0100 + r*8 + i));
      end
      check($sformatf("wrap[%0d].status_empty", r), 32'(status_a), 0);
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();

    // Same-flow simultaneous read and write keeps occupancy at 4.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 16'(16'h0200 + i), 1'b0, '0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd0, 16'(16'h0204 + i), 1'b1, 2'd0);
      tick();
      check($sformatf("rw[%0d].vld", i),    32'(vld_a),    1);
      check($sformatf("rw[%0d].dout", i),   32'(dout_a),   32'(16'h0200 + i));
      check($sformatf("rw[%0d].status", i), 32'(status_a), 32'(st(0, 4)));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 2'd0);
      tick();
      check($sformatf("rw_drain[%0d].dout", i), 32'(dout_a), 32'(16'h020A + i));
    end
    check("rw_drain.empty", 32'(empty_a), 32'hF);

    // Round robin over flows 0, 1 and 3 (two words each).
    do_reset();
    check("rr.reset_empty", 32'(empty_r), 32'hF);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'd0, 16'hF000, 1'b0, '0); tick();
      drive(1'b1, 2'd1, 16'hF001, 1'b0, '0); tick();
      drive(1'b1, 2'd3, 16'hF003, 1'b0, '0); tick();
    end
    check("rr.loaded_empty", 32'(empty_r), 32'h4);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, 1'b1, 2'd0);
      tick();
      check($sformatf("rr[%0d].vld", i),   32'(vld_r),   1);
      check($sformatf("rr[%0d].dflow", i), 32'(dflow_r), 32'(seq[i]));
      check($sformatf("rr[%0d].dout", i),  32'(dout_r),  32'(16'hF000 + seq[i]));
    end
    tick();
    check("rr.seventh_vld", 32'(vld_r),   0);
    check("rr.final_empty", 32'(empty_r), 32'hF);

    // Asynchronous reset while a read is in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, 16'(16'h0A00 + i), 1'b0, '0);
      tick();
    end
    drive(1'b1, 2'd1, 16'h0B00, 1'b1, 2'd2);
    tick();
    check("arst.inflight_vld", 32'(vld_a),   1);
    check("arst.inflight_dout", 32'(dout_a), 32'h0A00);
    drive(1'b0, '0, '0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.empty",  32'(empty_a),  32'hF);
    check("arst.status", 32'(status_a), 0);
    check("arst.vld",    32'(vld_a),    0);
    check("arst.dout",   32'(dout_a),   0);
    check("arst.vld_rr", 32'(vld_r),    0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 2'd2);
    tick();
    check("arst.lost_vld", 32'(vld_a), 0);

    // Boundary timing: write to empty flow 3 with a same-edge read (no bypass).
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    check("bound.pre_empty3", 32'(empty_a[3]), 1);
    drive(1'b1, 2'd3, 16'h3333, 1'b1, 2'd3);
    tick();
    check("bound.no_bypass_vld", 32'(vld_a),      0);
    check("bound.empty3",        32'(empty_a[3]), 0);
    drive(1'b0, '0, '0, 1'b1, 2'd3);
    tick();
    check("bound.vld",   32'(vld_a),   1);
    check("bound.dout",  32'(dout_a),  32'h3333);
    check("bound.dflow", 32'(dflow_a), 3);
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    check("bound.vld_one_cycle", 32'(vld_a),   0);
    check("bound.final_empty",   32'(empty_a), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
